arbitro_memoria: RTL and testbench
==================================

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 The block SHALL have the ports below; one clock; reset is asynchronous and active-high.
REQ-002 clock  input  1  rising-edge clock shared with the CPU pipeline.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request; held high until i_ready.
REQ-005 i_addr  input  32  fetch address (the PC).
REQ-006 i_rdata  output  32  fetched instruction; valid while i_ready=1.
REQ-007 i_ready  output  1  one-cycle pulse completing a fetch.
REQ-008 d_req  input  1  data request from the MEM stage; held high until d_ready.
REQ-009 d_we  input  1  1=store, 0=load; sampled at grant.
REQ-010 d_addr  input  32  data address (ALU result).
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data; valid while d_ready=1.
REQ-013 d_ready  output  1  one-cycle pulse completing a data access.
REQ-014 address  output  32  registered address to the shared memory.
REQ-015 dadoW  output  32  registered write data to the shared memory.
REQ-016 lerMem  output  1  registered read strobe.
REQ-017 escMem  output  1  registered write strobe.
REQ-018 Mem_out  input  32  memory read data; valid the cycle after lerMem=1.
REQ-019 align_err  output  1  sticky flag for misaligned access.

Function
REQ-020 The FSM SHALL have the states IDLE, I_RD, D_RD and D_WR.
REQ-021 IDLE: the block SHALL grant d_req before i_req, except when starve_cnt==2 with i_req pending, in which case it SHALL grant the fetch.
REQ-022 Grant effects: address<=granted address with bits[1:0] forced to 0; load or fetch sets lerMem<=1; store sets escMem<=1 and dadoW<=d_wdata.
REQ-023 I_RD/D_RD: the block SHALL capture Mem_out into i_rdata/d_rdata, pulse the matching ready for 1 cycle, clear the strobe and return to IDLE.
REQ-024 D_WR: the block SHALL pulse d_ready for 1 cycle, clear escMem and return to IDLE.
REQ-025 Latency: request seen in IDLE -> ready asserted exactly 2 cycles later; no new grant in the cycle a ready is high.
REQ-026 starve_cnt (2 bits): increments on a data grant while i_req=1, saturates at 2, and clears on any instruction grant or when i_req=0.
REQ-027 Simultaneous i_req and d_req with starve_cnt<2: data wins and the fetch waits.
REQ-028 A request dropped before its ready SHALL still complete the access; the ready pulse is ignorable.
REQ-029 align_err SHALL set on any grant with address bits[1:0]!=0 and stay set until reset; the access still proceeds aligned.
REQ-030 lerMem and escMem SHALL never both be 1.
REQ-031 i_rdata and d_rdata SHALL hold their last value between pulses.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, lerMem=0, escMem=0, i_ready=0, d_ready=0, address=0, dadoW=0, i_rdata=0, d_rdata=0, starve_cnt=0, align_err=0.
REQ-033 An access in flight at reset SHALL be abandoned with no ready pulse; after release, arbitration restarts from IDLE.

Configuration
REQ-034 With the macro ARB_IBUF_EN defined, the block SHALL include a one-entry fetch buffer (valid bit, 30-bit tag, 32-bit word), filled on every I_RD completion.
REQ-035 With ARB_IBUF_EN defined, an IDLE fetch whose tag matches with valid=1 and no d_req pending SHALL pulse i_ready next cycle from the buffer with no memory strobe.
REQ-036 With ARB_IBUF_EN defined, a store grant to the buffered word address SHALL clear valid, and reset SHALL clear valid.
REQ-037 Without ARB_IBUF_EN, every fetch SHALL access memory per REQ-021..025.

Verification
REQ-038 Fetch only: i_req=1, i_addr=0x40, Mem_out=0x8C010004 -> lerMem=1 at cycle 1, i_ready=1 with i_rdata=0x8C010004 at cycle 2.
REQ-039 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> escMem=1, address=0x100, dadoW=0xDEADBEEF, d_ready pulse 2 cycles later.
REQ-040 Contention: i_req and d_req held continuously -> grant order D,D,I,D,D,I; no fetch waits more than 3 grants.
REQ-041 Misaligned load d_addr=0x102 -> address=0x100, align_err=1, and it stays 1 after later aligned accesses.
REQ-042 Reset asserted in D_RD -> lerMem=0 and d_ready=0 immediately; no d_ready pulse after release.
REQ-043 With ARB_IBUF_EN, repeat fetch of 0x40 -> i_ready in 1 cycle with lerMem=0; after a store to 0x40, the next fetch of 0x40 -> memory read, 2 cycles.

Source files
------------

// File: rtl/arbitro_memoria.sv
// ---------------------------------------------------------------------------
// arbitro_memoria
//
// Arbiter that shares one single-port memory between the CPU instruction
// fetch and the MEM-stage data port. An access takes three cycles:
//   cycle 0  request seen in IDLE, grant registered
//   cycle 1  strobe (lerMem / escMem) and address on the memory bus
//   cycle 2  ready pulse with captured read data; no grant in this cycle
// Data requests win over fetches. A 2-bit starvation counter forces a fetch
// grant after two back-to-back data grants while a fetch is waiting.
//
// Optional feature (define ARB_IBUF_EN): a one-entry fetch buffer holding
// the last word fetched from memory. A repeat fetch of that word is answered
// from the buffer in one cycle with no memory strobe, provided no data
// request is pending. A store to the buffered word invalidates it.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ready) and PC
//   i_rdata/i_ready     fetched word, valid during the one-cycle i_ready pulse
//   d_req/d_we/d_addr   data request (held until d_ready), 1=store, address
//   d_wdata             store data
//   d_rdata/d_ready     load data, valid during the one-cycle d_ready pulse
//   address/dadoW       registered memory address (word aligned) / write data
//   lerMem/escMem       registered read / write strobes, never both high
//   Mem_out             memory read data, captured at the end of a read cycle
//   align_err           sticky: some granted address had bits[1:0] != 0
// ---------------------------------------------------------------------------
module arbitro_memoria (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] address,
    output logic [31:0] dadoW,
    output logic        lerMem,
    output logic        escMem,
    input  logic [31:0] Mem_out,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [1:0]  starve_cnt, starve_n;
    logic [31:0] address_n, dadoW_n, i_rdata_n, d_rdata_n;
    logic        lerMem_n, escMem_n, i_ready_n, d_ready_n, align_n;

    logic        idle_open;
    logic        grant_d, grant_i;
    logic [31:0] d_word, i_word;

`ifdef ARB_IBUF_EN
    logic        ibuf_valid, ibuf_valid_n;
    logic [29:0] ibuf_tag, ibuf_tag_n;
    logic [31:0] ibuf_word, ibuf_word_n;
    logic        ibuf_hit;
`endif

    // A ready pulse marks the cycle after completion; arbitration is held
    // off then so a requester still holding its req is not granted twice.
    assign idle_open = !i_ready && !d_ready;

    // Data has priority unless the fetch has already lost two grants in a row.
    assign grant_d = d_req && !(i_req && (starve_cnt == 2'd2));
    assign grant_i = i_req && !grant_d;

    // Accesses always go out word aligned, even when the request was not.
    assign d_word = {d_addr[31:2], 2'b00};
    assign i_word = {i_addr[31:2], 2'b00};

`ifdef ARB_IBUF_EN
    // Buffer service is only taken when the data port is quiet, so a pending
    // data access is never delayed behind a buffer hit.
    assign ibuf_hit = ibuf_valid && (ibuf_tag == i_addr[31:2]) && !d_req;
`endif

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        starve_n  = i_req ? starve_cnt : 2'd0;
        address_n = address;
        dadoW_n   = dadoW;
        lerMem_n  = lerMem;
        escMem_n  = escMem;
        i_ready_n = 1'b0;
        d_ready_n = 1'b0;
        i_rdata_n = i_rdata;
        d_rdata_n = d_rdata;
        align_n   = align_err;
`ifdef ARB_IBUF_EN
        ibuf_valid_n = ibuf_valid;
        ibuf_tag_n   = ibuf_tag;
        ibuf_word_n  = ibuf_word;
`endif

        case (state)
            IDLE: begin
                if (idle_open && grant_d) begin
                    address_n = d_word;
                    if (d_addr[1:0] != 2'b00)
                        align_n = 1'b1;
                    // Count data grants that overtook a waiting fetch.
                    if (i_req && (starve_cnt != 2'd2))
                        starve_n = starve_cnt + 2'd1;
                    if (d_we) begin
                        escMem_n = 1'b1;
                        dadoW_n  = d_wdata;
                        state_n  = D_WR;
`ifdef ARB_IBUF_EN
                        if (ibuf_tag == d_addr[31:2])
                            ibuf_valid_n = 1'b0;
`endif
                    end else begin
                        lerMem_n = 1'b1;
                        state_n  = D_RD;
                    end
                end else if (idle_open && grant_i) begin
                    if (i_addr[1:0] != 2'b00)
                        align_n = 1'b1;
                    starve_n = 2'd0;
`ifdef ARB_IBUF_EN
                    if (ibuf_hit) begin
                        i_ready_n = 1'b1;
                        i_rdata_n = ibuf_word;
                    end else begin
                        address_n = i_word;
                        lerMem_n  = 1'b1;
                        state_n   = I_RD;
                    end
`else
                    address_n = i_word;
                    lerMem_n  = 1'b1;
                    state_n   = I_RD;
`endif
                end
            end

            I_RD: begin
                i_rdata_n = Mem_out;
                i_ready_n = 1'b1;
                lerMem_n  = 1'b0;
                state_n   = IDLE;
`ifdef ARB_IBUF_EN
                ibuf_valid_n = 1'b1;
                ibuf_tag_n   = address[31:2];
                ibuf_word_n  = Mem_out;
`endif
            end

            D_RD: begin
                d_rdata_n = Mem_out;
                d_ready_n = 1'b1;
                lerMem_n  = 1'b0;
                state_n   = IDLE;
            end

            D_WR: begin
                d_ready_n = 1'b1;
                escMem_n  = 1'b0;
                state_n   = IDLE;
            end

            default: begin
                lerMem_n = 1'b0;
                escMem_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers. Reset abandons any access in flight: the
    // strobes and ready pulses drop immediately and no completion follows.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 2'd0;
            address    <= 32'd0;
            dadoW      <= 32'd0;
            lerMem     <= 1'b0;
            escMem     <= 1'b0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
            align_err  <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            address    <= address_n;
            dadoW      <= dadoW_n;
            lerMem     <= lerMem_n;
            escMem     <= escMem_n;
            i_ready    <= i_ready_n;
            d_ready    <= d_ready_n;
            i_rdata    <= i_rdata_n;
            d_rdata    <= d_rdata_n;
            align_err  <= align_n;
        end
    end

`ifdef ARB_IBUF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ibuf_valid <= 1'b0;
            ibuf_tag   <= 30'd0;
            ibuf_word  <= 32'd0;
        end else begin
            ibuf_valid <= ibuf_valid_n;
            ibuf_tag   <= ibuf_tag_n;
            ibuf_word  <= ibuf_word_n;
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria (default build). A small word memory answers the
// DUT's bus; requesters push the expected responses into queues when they
// issue, and a negedge monitor pops and compares on every ready / write.
module tb_arbitro_memoria;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, address, dadoW, Mem_out;
    logic        i_ready, d_ready, lerMem, escMem, align_err;

    arbitro_memoria dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .address(address), .dadoW(dadoW), .lerMem(lerMem), .escMem(escMem),
        .Mem_out(Mem_out), .align_err(align_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Initial contents of the 256-word memory; word 0x40 carries the
    // instruction used by the directed fetch.
    function automatic logic [31:0] seed_word(input int i);
        if (i == 16) return 32'h8C01_0004;
        return 32'h1357_0000 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // Environment memory: initialised on the first edge, written by escMem.
    logic [31:0] mem [0:255];
    logic        mem_init_done = 1'b0;
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
            mem_init_done <= 1'b1;
        end else if (escMem) begin
            mem[address[9:2]] <= dadoW;
        end
    end
    assign Mem_out = mem[address[9:2]];

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic        m_align;

    typedef struct packed { logic st; logic [31:0] data; } dexp_t;
    logic [31:0] exp_i [$];
    dexp_t       exp_d [$];
    logic [63:0] exp_w [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push_i(input logic [31:0] a);
        exp_i.push_back(ref_mem[a[9:2]]);
        if (a[1:0] != 2'b00) m_align = 1'b1;
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        if (a[1:0] != 2'b00) m_align = 1'b1;
        if (we) begin
            ref_mem[a[9:2]] = wd;
            exp_w.push_back({a[31:2], 2'b00, wd});
            exp_d.push_back({1'b1, 32'h0});
        end else begin
            exp_d.push_back({1'b0, ref_mem[a[9:2]]});
        end
    endtask

    function automatic logic [31:0] rand_addr(input int lo, input int hi);
        logic [31:0] a;
        a = 32'($urandom_range(hi, lo)) << 2;
        if ($urandom_range(7, 0) == 0) a[1:0] = 2'($urandom_range(3, 1));
        return a;
    endfunction

    task automatic fetch_txn(input logic [31:0] a);
        int waitc, dseen;
        i_addr = a;
        i_req  = 1'b1;
        push_i(a);
        waitc = 0;
        dseen = 0;
        do begin
            cyc();
            waitc++;
            if (d_ready) dseen++;
        end while (!i_ready && waitc < 40);
        chk("fetch_completes", 64'(i_ready), 64'd1);
        // A fetch may see one data access already in flight plus two more.
        chk("fetch_max_wait_grants", 64'(dseen <= 3), 64'd1);
        i_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd);
        int waitc;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        push_d(we, a, wd);
        waitc = 0;
        do begin
            cyc();
            waitc++;
        end while (!d_ready && waitc < 40);
        chk("data_completes", 64'(d_ready), 64'd1);
        d_req = 1'b0;
    endtask

    // Monitor / scoreboard
    int          both_viol = 0;
    int          hold_viol = 0;
    logic [31:0] last_i = '0, last_d = '0;
    always @(negedge clock) begin
        logic [31:0] ie;
        dexp_t       de;
        logic [63:0] we;
        if (lerMem && escMem) both_viol++;
        if (reset) begin
            last_i = '0;
            last_d = '0;
        end else begin
            if (!i_ready && i_rdata !== last_i) hold_viol++;
            if (!d_ready && d_rdata !== last_d) hold_viol++;
            last_i = i_rdata;
            last_d = d_rdata;
        end
        if (i_ready) begin
            if (exp_i.size() == 0) chk("unexpected_i_ready", 64'd1, 64'd0);
            else begin
                ie = exp_i.pop_front();
                chk("i_rdata", 64'(i_rdata), 64'(ie));
            end
        end
        if (d_ready) begin
            if (exp_d.size() == 0) chk("unexpected_d_ready", 64'd1, 64'd0);
            else begin
                de = exp_d.pop_front();
                if (!de.st) chk("d_rdata", 64'(d_rdata), 64'(de.data));
            end
        end
        if (escMem) begin
            if (exp_w.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
            else begin
                we = exp_w.pop_front();
                chk("wr_address", 64'(address), 64'(we[63:32]));
                chk("wr_data", 64'(dadoW), 64'(we[31:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] seq;
        int ng, nr;
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        m_align = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

        // Reset state
        repeat (2) cyc();
        chk("rst_lerMem", 64'(lerMem), 0);
        chk("rst_escMem", 64'(escMem), 0);
        chk("rst_readies", 64'({i_ready, d_ready}), 0);
        chk("rst_address", 64'(address), 0);
        chk("rst_dadoW", 64'(dadoW), 0);
        chk("rst_rdata", 64'({i_rdata, d_rdata}), 0);
        chk("rst_align_err", 64'(align_err), 0);
        reset = 1'b0;
        cyc();

        // Fetch only: strobe at cycle 1, ready at cycle 2
        i_addr = 32'h40; i_req = 1'b1; push_i(32'h40);
        cyc();
        chk("fetch_lerMem_c1", 64'(lerMem), 1);
        chk("fetch_address_c1", 64'(address), 64'h40);
        chk("fetch_ready_c1", 64'(i_ready), 0);
        cyc();
        chk("fetch_ready_c2", 64'(i_ready), 1);
        chk("fetch_rdata_c2", 64'(i_rdata), 64'h8C01_0004);
        chk("fetch_lerMem_c2", 64'(lerMem), 0);
        i_req = 1'b0;
        cyc();

        // Store
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        push_d(1'b1, 32'h100, 32'hDEAD_BEEF);
        cyc();
        chk("store_escMem_c1", 64'(escMem), 1);
        chk("store_lerMem_c1", 64'(lerMem), 0);
        chk("store_address_c1", 64'(address), 64'h100);
        chk("store_dadoW_c1", 64'(dadoW), 64'hDEAD_BEEF);
        cyc();
        chk("store_ready_c2", 64'(d_ready), 1);
        chk("store_escMem_c2", 64'(escMem), 0);
        d_req = 1'b0;
        cyc();
        chk("align_clean", 64'(align_err), 0);

        // Misaligned load reads the aligned word and flags it
        d_we = 1'b0; d_addr = 32'h102; d_req = 1'b1;
        push_d(1'b0, 32'h102, 32'h0);
        cyc();
        chk("misal_address", 64'(address), 64'h100);
        chk("misal_align_err", 64'(align_err), 1);
        cyc();
        chk("misal_ready", 64'(d_ready), 1);
        d_req = 1'b0;
        cyc();

        // Contention: both held continuously for six grants
        push_i(32'h80); push_i(32'h80);
        repeat (4) push_d(1'b0, 32'h200, 32'h0);
        i_addr = 32'h80; i_req = 1'b1;
        d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
        seq = '0; ng = 0; nr = 0;
        for (int c = 0; c < 40 && nr < 6; c++) begin
            cyc();
            if (lerMem) begin
                seq = {seq[4:0], address == 32'h80};
                ng++;
            end
            if (i_ready || d_ready) nr++;
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("contention_grants", 64'(ng), 6);
        chk("contention_order_DDIDDI", 64'(seq), 64'b001001);
        chk("align_sticky", 64'(align_err), 1);
        cyc();

        // Reset during D_RD abandons the load
        d_we = 1'b0; d_addr = 32'h204; d_req = 1'b1;
        cyc();
        chk("inflight_lerMem", 64'(lerMem), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_lerMem", 64'(lerMem), 0);
        chk("abort_d_ready", 64'(d_ready), 0);
        chk("abort_align_err", 64'(align_err), 0);
        m_align = 1'b0;
        d_req = 1'b0;
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("no_ready_after_abort", 64'({d_ready, lerMem}), 0);
        end

        // Randomized traffic: fetches from 0x000-0x0FC, data in 0x200-0x3FC
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(3, 1)) cyc();
                    fetch_txn(rand_addr(0, 63));
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(3, 0)) cyc();
                    data_txn(1'($urandom_range(1, 0)), rand_addr(128, 255), $urandom);
                end
            end
        join
        repeat (5) cyc();

        chk("exp_i_drained", 64'(exp_i.size()), 0);
        chk("exp_d_drained", 64'(exp_d.size()), 0);
        chk("exp_w_drained", 64'(exp_w.size()), 0);
        chk("strobe_exclusive", 64'(both_viol), 0);
        chk("rdata_hold", 64'(hold_viol), 0);
        chk("align_err_final", 64'(align_err), 64'(m_align));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
